// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline hazard/stall/flush controller with scoreboard
//
// Purpose: tracks in-flight destination registers in a 3-entry scoreboard
// (EX, MEM, WB) and drives freeze/flush controls for the PC, IF2ID and ID2EX
// pipeline registers. A small FSM (INIT, RUN, STALL, BRANCH) sequences
// start-up flushing, read-after-write stalls and taken-branch squashing.
//
// Optional feature macro: HAZ_FORWARD_EN
//   defined   -> only a load in EX can cause a stall (load-use); MEM/WB forward
//   undefined -> any valid EX/MEM/WB producer stalls the reader
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   id_a_reg, id_b_reg    source register addresses of the ID instruction
//   id_a_use, id_b_use    source operand actually read
//   id_w_reg, id_w_en     destination register / write enable of ID instruction
//   id_is_load            ID instruction is a memory load
//   ex_branch_taken       branch resolved taken in EX this cycle
//   pc_freeze             hold PC
//   if2id_freeze          hold IF2ID register
//   if2id_flush           invalidate IF2ID register
//   id2ex_flush           inject bubble into ID2EX register
//   state_o               current FSM state (INIT=0, RUN=1, STALL=2, BRANCH=3)
//   stall_cnt             saturating count of STALL-state cycles since reset

module pipe_hazard_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  id_a_reg,
   input  logic [3:0]  id_b_reg,
   input  logic        id_a_use,
   input  logic        id_b_use,
   input  logic [3:0]  id_w_reg,
   input  logic        id_w_en,
   input  logic        id_is_load,
   input  logic        ex_branch_taken,
   output logic        pc_freeze,
   output logic        if2id_freeze,
   output logic        if2id_flush,
   output logic        id2ex_flush,
   output logic [1:0]  state_o,
   output logic [15:0] stall_cnt
);

   typedef enum logic [1:0] {
      ST_INIT   = 2'd0,
      ST_RUN    = 2'd1,
      ST_STALL  = 2'd2,
      ST_BRANCH = 2'd3
   } state_t;

   // Scoreboard index: 0 = EX, 1 = MEM, 2 = WB
   state_t          state_q, state_d;
   logic            init_cnt_q, init_cnt_d;
   logic [15:0]     stall_cnt_q, stall_cnt_d;
   logic [2:0]      sb_valid_q, sb_valid_d;
   logic [2:0][3:0] sb_reg_q, sb_reg_d;
   logic [2:0]      sb_load_q, sb_load_d;

   logic            a_match;
   logic            b_match;
   logic            hazard;
   logic            advance;

   // Source operand match against in-flight producers
   always_comb begin
      a_match = 1'b0;
      b_match = 1'b0;
`ifdef HAZ_FORWARD_EN
      // MEM/WB results are forwarded; only a load still in EX has no data yet
      a_match = sb_valid_q[0] && sb_load_q[0] && (sb_reg_q[0] == id_a_reg);
      b_match = sb_valid_q[0] && sb_load_q[0] && (sb_reg_q[0] == id_b_reg);
`else
      for (int i = 0; i < 3; i++) begin
         if (sb_valid_q[i] && (sb_reg_q[i] == id_a_reg)) a_match = 1'b1;
         if (sb_valid_q[i] && (sb_reg_q[i] == id_b_reg)) b_match = 1'b1;
      end
`endif
      hazard = (id_a_use && a_match) || (id_b_use && b_match);
   end

`ifdef HAZ_FORWARD_EN
   // Deeper entries are kept for pipeline tracking but do not affect matching
   logic unused_sb;
   assign unused_sb = ^{sb_valid_q[2:1], sb_reg_q[2:1], sb_load_q[2:1]};
`else
   // Load flag only matters for load-use detection with forwarding
   logic unused_sb;
   assign unused_sb = ^sb_load_q;
`endif

   always_comb begin
      state_d      = state_q;
      init_cnt_d   = init_cnt_q;
      stall_cnt_d  = stall_cnt_q;
      pc_freeze    = 1'b0;
      if2id_freeze = 1'b0;
      if2id_flush  = 1'b0;
      id2ex_flush  = 1'b0;
      advance      = 1'b0;

      case (state_q)
         ST_INIT: begin
            if2id_flush = 1'b1;
            id2ex_flush = 1'b1;
            if (init_cnt_q) begin
               init_cnt_d = 1'b0;
               state_d    = ST_RUN;
            end else begin
               init_cnt_d = 1'b1;
            end
         end
         ST_RUN, ST_STALL: begin
            // Branch wins over hazard: the stalled instruction is wrong-path
            if (ex_branch_taken) begin
               if2id_flush = 1'b1;
               id2ex_flush = 1'b1;
               state_d     = ST_BRANCH;
            end else if (hazard) begin
               pc_freeze    = 1'b1;
               if2id_freeze = 1'b1;
               id2ex_flush  = 1'b1;
               state_d      = ST_STALL;
            end else begin
               advance = 1'b1;
               state_d = ST_RUN;
            end
            if ((state_q == ST_STALL) && !ex_branch_taken &&
                (stall_cnt_q != 16'hFFFF)) begin
               stall_cnt_d = stall_cnt_q + 16'd1;
            end
         end
         ST_BRANCH: begin
            // Squash the wrong-path instruction currently sitting in ID
            id2ex_flush = 1'b1;
            state_d     = ST_RUN;
         end
         default: begin
            state_d = ST_INIT;
         end
      endcase

      // Reset held: present INIT controls regardless of registered state
      if (!rst_n) begin
         pc_freeze    = 1'b0;
         if2id_freeze = 1'b0;
         if2id_flush  = 1'b1;
         id2ex_flush  = 1'b1;
      end

      sb_valid_d    = {sb_valid_q[1:0], advance && id_w_en};
      sb_reg_d      = {sb_reg_q[1:0], id_w_reg};
      sb_load_d     = {sb_load_q[1:0], id_is_load};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_INIT;
         init_cnt_q  <= 1'b0;
         stall_cnt_q <= 16'd0;
         sb_valid_q  <= 3'b000;
         sb_reg_q    <= '0;
         sb_load_q   <= 3'b000;
      end else begin
         state_q     <= state_d;
         init_cnt_q  <= init_cnt_d;
         stall_cnt_q <= stall_cnt_d;
         sb_valid_q  <= sb_valid_d;
         sb_reg_q    <= sb_reg_d;
         sb_load_q   <= sb_load_d;
      end
   end

   assign state_o   = state_q;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - table-driven self-checking bench for pipe_hazard_ctrl

module tb_pipe_hazard_ctrl;

   logic        clk;
   logic        rst_n;
   logic [3:0]  id_a_reg;
   logic [3:0]  id_b_reg;
   logic        id_a_use;
   logic        id_b_use;
   logic [3:0]  id_w_reg;
   logic        id_w_en;
   logic        id_is_load;
   logic        ex_branch_taken;
   logic        pc_freeze;
   logic        if2id_freeze;
   logic        if2id_flush;
   logic        id2ex_flush;
   logic [1:0]  state_o;
   logic [15:0] stall_cnt;

   int n_checks = 0;
   int n_errors = 0;

   pipe_hazard_ctrl dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .id_a_reg        (id_a_reg),
      .id_b_reg        (id_b_reg),
      .id_a_use        (id_a_use),
      .id_b_use        (id_b_use),
      .id_w_reg        (id_w_reg),
      .id_w_en         (id_w_en),
      .id_is_load      (id_is_load),
      .ex_branch_taken (ex_branch_taken),
      .pc_freeze       (pc_freeze),
      .if2id_freeze    (if2id_freeze),
      .if2id_flush     (if2id_flush),
      .id2ex_flush     (id2ex_flush),
      .state_o         (state_o),
      .stall_cnt       (stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Controls packed as {pc_freeze, if2id_freeze, if2id_flush, id2ex_flush}
   localparam logic [3:0] C_IDLE  = 4'b0000;
   localparam logic [3:0] C_INIT  = 4'b0011;
   localparam logic [3:0] C_STALL = 4'b1101;
   localparam logic [3:0] C_BR    = 4'b0011;
   localparam logic [3:0] C_BRST  = 4'b0001;

   localparam logic [1:0] S_INIT   = 2'd0;
   localparam logic [1:0] S_RUN    = 2'd1;
   localparam logic [1:0] S_STALL  = 2'd2;
   localparam logic [1:0] S_BRANCH = 2'd3;

   typedef struct {
      logic        rst_n;
      logic [3:0]  a_reg;
      logic        a_use;
      logic [3:0]  b_reg;
      logic        b_use;
      logic [3:0]  w_reg;
      logic        w_en;
      logic        ld;
      logic        br;
      logic [3:0]  exp_ctl;
      logic [1:0]  exp_st;
      logic [15:0] exp_cnt;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic [3:0] a, input logic au,
                      input logic [3:0] b, input logic bu, input logic [3:0] w,
                      input logic we, input logic ld, input logic br,
                      input logic [3:0] ctl, input logic [1:0] st,
                      input logic [15:0] cnt);
      vec_t v;
      v.rst_n = r;  v.a_reg = a; v.a_use = au; v.b_reg = b; v.b_use = bu;
      v.w_reg = w;  v.w_en = we; v.ld = ld;    v.br = br;
      v.exp_ctl = ctl; v.exp_st = st; v.exp_cnt = cnt;
      vecs.push_back(v);
   endtask

   task automatic drive(input vec_t v);
      rst_n           = v.rst_n;
      id_a_reg        = v.a_reg;
      id_a_use        = v.a_use;
      id_b_reg        = v.b_reg;
      id_b_use        = v.b_use;
      id_w_reg        = v.w_reg;
      id_w_en         = v.w_en;
      id_is_load      = v.ld;
      ex_branch_taken = v.br;
   endtask

   // IF2ID can never be held and invalidated at once
   always @(negedge clk) begin
      n_checks++;
      if (if2id_freeze && if2id_flush) begin
         n_errors++;
         $display("FAIL freeze_flush_excl t=%0t: if2id_freeze=%b if2id_flush=%b, required not both 1",
                  $time, if2id_freeze, if2id_flush);
      end
   end

   initial begin
      logic [21:0] got;
      logic [21:0] exp;
      int          cyc;

      rst_n = 1'b0; id_a_reg = 4'd0; id_b_reg = 4'd0; id_a_use = 1'b0;
      id_b_use = 1'b0; id_w_reg = 4'd0; id_w_en = 1'b0; id_is_load = 1'b0;
      ex_branch_taken = 1'b0;

`ifdef HAZ_FORWARD_EN
      add(0, 0,0, 0,0, 0,0,0,0, C_INIT,  S_INIT,  16'd0);
      add(1, 0,0, 0,0, 0,0,0,0, C_INIT,  S_INIT,  16'd0);
      add(1, 0,0, 0,0, 0,0,0,0, C_INIT,  S_INIT,  16'd0);
      add(1, 0,0, 0,0, 0,0,0,0, C_IDLE,  S_RUN,   16'd0);
      add(1, 0,0, 0,0, 5,1,1,0, C_IDLE,  S_RUN,   16'd0);  // load R5
      add(1, 5,1, 0,0, 0,0,0,0, C_STALL, S_RUN,   16'd0);  // load-use
      add(1, 5,1, 0,0, 0,0,0,0, C_IDLE,  S_STALL, 16'd0);  // load in MEM: forwarded
      add(1, 0,0, 0,0, 0,0,0,0, C_IDLE,  S_RUN,   16'd1);
      add(1, 0,0, 0,0, 5,1,0,0, C_IDLE,  S_RUN,   16'd1);  // ALU op to R5
      add(1, 5,1, 0,0, 0,0,0,0, C_IDLE,  S_RUN,   16'd1);  // no stall
      add(1, 0,0, 0,0, 0,0,0,0, C_IDLE,  S_RUN,   16'd1);
`else
      add(0, 0,0, 0,0, 0,0,0,0, C_INIT,  S_INIT,   16'd0);  // reset held
      add(1, 0,0, 0,0, 0,0,0,0, C_INIT,  S_INIT,   16'd0);  // INIT cycle 1
      add(1, 0,0, 0,0, 0,0,0,0, C_INIT,  S_INIT,   16'd0);  // INIT cycle 2
      add(1, 0,0, 0,0, 0,0,0,0, C_IDLE,  S_RUN,    16'd0);  // RUN at cycle 3
      add(1, 0,0, 0,0, 3,1,0,0, C_IDLE,  S_RUN,    16'd0);  // writes R3
      add(1, 3,1, 0,0, 4,0,0,0, C_STALL, S_RUN,    16'd0);  // EX match
      add(1, 3,1, 0,0, 4,0,0,0, C_STALL, S_STALL,  16'd0);  // MEM match
      add(1, 3,1, 0,0, 4,0,0,0, C_STALL, S_STALL,  16'd1);  // WB match
      add(1, 3,1, 0,0, 4,0,0,0, C_IDLE,  S_STALL,  16'd2);  // clear, advance
      add(1, 0,0, 0,0, 0,0,0,0, C_IDLE,  S_RUN,    16'd3);
      add(1, 0,0, 0,0, 7,1,0,0, C_IDLE,  S_RUN,    16'd3);  // writes R7
      add(1, 7,0, 7,0, 0,0,0,0, C_IDLE,  S_RUN,    16'd3);  // R7 named, not used
      add(1, 0,0, 7,1, 0,0,0,0, C_STALL, S_RUN,    16'd3);  // b operand, MEM match
      add(1, 0,0, 7,1, 0,0,0,1, C_BR,    S_STALL,  16'd3);  // branch beats hazard
      add(1, 0,0, 7,1, 0,0,0,1, C_BRST,  S_BRANCH, 16'd3);  // branch ignored here
      add(1, 0,0, 7,1, 0,0,0,0, C_IDLE,  S_RUN,    16'd3);
      add(1, 0,0, 0,0, 0,1,0,0, C_IDLE,  S_RUN,    16'd3);  // writes R0
      add(1, 0,1, 0,0, 0,0,0,0, C_STALL, S_RUN,    16'd3);  // R0 not exempt
      add(1, 0,1, 0,0, 0,0,0,0, C_STALL, S_STALL,  16'd3);
      add(0, 0,1, 0,0, 0,0,0,0, C_INIT,  S_STALL,  16'd4);  // reset mid-STALL
      add(1, 0,1, 0,0, 0,0,0,0, C_INIT,  S_INIT,   16'd0);
      add(1, 0,1, 0,0, 0,0,0,0, C_INIT,  S_INIT,   16'd0);
      add(1, 0,1, 0,0, 0,0,0,0, C_IDLE,  S_RUN,    16'd0);  // scoreboard empty
      add(1, 0,0, 0,0, 9,1,0,1, C_BR,    S_RUN,    16'd0);  // branch in RUN
      add(1, 9,1, 0,0, 0,0,0,0, C_BRST,  S_BRANCH, 16'd0);
      add(1, 9,1, 0,0, 0,0,0,0, C_IDLE,  S_RUN,    16'd0);  // squashed writer
`endif

      repeat (3) @(posedge clk);
      #1;
      foreach (vecs[i]) begin
         drive(vecs[i]);
         #1;
         got = {pc_freeze, if2id_freeze, if2id_flush, id2ex_flush, state_o, stall_cnt};
         exp = {vecs[i].exp_ctl, vecs[i].exp_st, vecs[i].exp_cnt};
         n_checks++;
         if (got !== exp) begin
            n_errors++;
            $display("FAIL vec%0d: got ctl=%b st=%0d cnt=%0d, required ctl=%b st=%0d cnt=%0d",
                     i, got[21:18], got[17:16], got[15:0],
                     exp[21:18], exp[17:16], exp[15:0]);
         end
         @(posedge clk);
         #1;
      end

`ifndef HAZ_FORWARD_EN
      // Self-dependent instruction re-stalls continuously: drive counter to saturation
      id_a_reg = 4'd3; id_a_use = 1'b1; id_b_use = 1'b0;
      id_w_reg = 4'd3; id_w_en = 1'b1; id_is_load = 1'b0; ex_branch_taken = 1'b0;
      cyc = 0;
      while ((stall_cnt !== 16'hFFFF) && (cyc < 90000)) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      n_checks++;
      if (stall_cnt !== 16'hFFFF) begin
         n_errors++;
         $display("FAIL sat_reach: stall_cnt=%h after %0d cycles, required ffff", stall_cnt, cyc);
      end
      repeat (40) @(posedge clk);
      #1;
      n_checks++;
      if (stall_cnt !== 16'hFFFF) begin
         n_errors++;
         $display("FAIL sat_hold: stall_cnt=%h, required ffff", stall_cnt);
      end
      n_checks++;
      if ((state_o !== S_RUN) && (state_o !== S_STALL)) begin
         n_errors++;
         $display("FAIL sat_state: state=%0d, required RUN or STALL", state_o);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
